play_core: RTL and testbench

//  Playback engine downstream of the control FSM: on play_start it streams CHUNK_WORDS
//  16-bit samples from external memory, starting at the selected chunk base address.

---
 rtl/play_core.sv | 180 ++++++++++++++++++
 tb/tb_play_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_core.sv
// play_core: streams one chunk of samples from word-addressed memory to the DAC, one per codec request.
// Optional build macro PLAY_LOOP_EN: replay the chunk from its base address until i_stop.
module play_core #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int CHUNK_WORDS = 1048576
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_select,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic              o_done,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_dac_req,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_underrun
);

    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CHUNK_LEN = CNT_W'(CHUNK_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              buf_full_q, buf_full_d;
    logic              mem_req_q, mem_req_d;
    logic              stop_pend_q, stop_pend_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
`ifdef PLAY_LOOP_EN
    logic [ADDR_W-1:0] base_q, base_d;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        dac_data_d  = dac_data_q;
        buf_full_d  = buf_full_q;
        mem_req_d   = mem_req_q;
        stop_pend_d = stop_pend_q;
        underrun_d  = 1'b0;
`ifdef PLAY_LOOP_EN
        base_d      = base_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d      = i_select;
                    cnt_d       = '0;
                    buf_full_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = S_FETCH;
`ifdef PLAY_LOOP_EN
                    base_d      = i_select;
`endif
                end
            end
            S_FETCH: begin
                // An outstanding request is never withdrawn; a stop only marks its data for discard.
                if (mem_req_q) begin
                    if (i_stop) begin
                        stop_pend_d = 1'b1;
                    end
                    if (i_mem_ack) begin
                        mem_req_d = 1'b0;
                        if (i_stop || stop_pend_q) begin
                            dac_data_d = '0;
                            state_d    = S_DONE;
                        end else begin
                            buf_d      = i_mem_rdata;
                            buf_full_d = 1'b1;
                            addr_d     = addr_q + ADDR_W'(1);
                            cnt_d      = cnt_q + CNT_W'(1);
                            state_d    = S_HOLD;
                        end
                    end
                end else if (i_stop) begin
                    dac_data_d = '0;
                    state_d    = S_DONE;
                end else if (!i_pause) begin
                    mem_req_d = 1'b1;
                end
                if (i_dac_req && !buf_full_q && !i_pause && !i_stop && !stop_pend_q) begin
                    dac_data_d = '0;
                    underrun_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_stop) begin
                    dac_data_d = '0;
                    state_d    = S_DONE;
                end else if (!i_pause && i_dac_req && buf_full_q) begin
                    dac_data_d = buf_q;
                    buf_full_d = 1'b0;
                    if (cnt_q < CHUNK_LEN) begin
                        state_d = S_FETCH;
                    end else begin
`ifdef PLAY_LOOP_EN
                        addr_d  = base_q;
                        cnt_d   = '0;
                        state_d = S_FETCH;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                dac_data_d  = '0;
                buf_full_d  = 1'b0;
                stop_pend_d = 1'b0;
                state_d     = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold here until the control FSM lets go of i_start so it cannot retrigger.
                if (!i_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            dac_data_q  <= '0;
            buf_full_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef PLAY_LOOP_EN
            base_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            dac_data_q  <= dac_data_d;
            buf_full_q  <= buf_full_d;
            mem_req_q   <= mem_req_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
`ifdef PLAY_LOOP_EN
            base_q      <= base_d;
`endif
        end
    end

    assign o_done     = done_q;
    assign o_mem_req  = mem_req_q;
    assign o_mem_addr = addr_q;
    assign o_dac_data = dac_data_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_play_core.sv
// tb_play_core: directed playback scenarios with a 3-cycle-latency memory model and sample/address scoreboards.
// Build with PLAY_LOOP_EN defined to exercise chunk looping instead of single-pass wrap-around.
module tb_play_core;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [22:0] i_select;
    logic        i_pause;
    logic        i_stop;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        i_dac_req;
    logic        o_done;
    logic        o_mem_req;
    logic [22:0] o_mem_addr;
    logic [15:0] o_dac_data;
    logic        o_underrun;

    play_core #(
        .ADDR_W(23),
        .DATA_W(16),
        .CHUNK_WORDS(4)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_select(i_select),
        .i_pause(i_pause),
        .i_stop(i_stop),
        .o_done(o_done),
        .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata),
        .i_dac_req(i_dac_req),
        .o_dac_data(o_dac_data),
        .o_underrun(o_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          assert_count = 0;
    int          fail_count   = 0;
    int          req_count    = 0;
    int          done_count   = 0;
    int          sample_count = 0;
    int          underrun_count = 0;
    int          mem_wait     = 0;
    int          dac_period   = 0;
    int          dac_cnt      = 0;
    logic        model_full   = 1'b0;
    logic        prev_req     = 1'b0;
    logic        prev_done    = 1'b0;
    logic [22:0] exp_addr[$];
    logic [15:0] exp_samp[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [22:0] sel, input logic pause,
                                 input logic stop, input int period);
        i_start  = start;
        i_select = sel;
        i_pause  = pause;
        i_stop   = stop;
        if (period != dac_period) begin
            dac_period = period;
            dac_cnt    = 0;
            i_dac_req  = 1'b0;
        end
    endtask

    // Scoreboard: inputs still hold the values the DUT sampled at the edge just passed.
    task automatic monitor();
        logic [15:0] exp_s;
        logic [22:0] exp_a;
        if (i_rst) begin
            model_full = 1'b0;
        end else begin
            if (i_dac_req && !i_pause && !i_stop && model_full) begin
                sample_count++;
                model_full = 1'b0;
                checkOutput("sample_queued", exp_samp.size() > 0, 1);
                if (exp_samp.size() > 0) begin
                    exp_s = exp_samp.pop_front();
                    checkOutput("dac_data", o_dac_data, exp_s);
                end
            end
            if (i_mem_ack && !i_stop) model_full = 1'b1;
        end
        if (o_underrun) begin
            underrun_count++;
            checkOutput("underrun_data", o_dac_data, 0);
        end
        if (o_mem_req && !prev_req) begin
            req_count++;
            checkOutput("req_queued", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) begin
                exp_a = exp_addr.pop_front();
                checkOutput("req_addr", o_mem_addr, exp_a);
            end
        end
        if (o_done) begin
            done_count++;
            checkOutput("done_width", prev_done, 0);
        end
        prev_req  = o_mem_req;
        prev_done = o_done;
    endtask

    // One clock: check just after the edge, then drive memory and codec models.
    task automatic tick();
        @(posedge i_clk);
        #1;
        monitor();
        #1;
        if (i_rst || i_mem_ack) begin
            i_mem_ack = 1'b0;
            mem_wait  = 0;
        end else if (o_mem_req) begin
            mem_wait++;
            if (mem_wait == 3) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = o_mem_addr[15:0];
            end
        end else begin
            mem_wait = 0;
        end
        if (dac_period == 0) begin
            dac_cnt   = 0;
            i_dac_req = 1'b0;
        end else begin
            dac_cnt++;
            i_dac_req = (dac_cnt >= dac_period);
            if (i_dac_req) dac_cnt = 0;
        end
    endtask

    task automatic startPlay(input logic [22:0] sel, input int n_addr, input int n_samp, input int period);
        logic [22:0] a;
        model_full = 1'b0;
        for (int k = 0; k < n_addr; k++) begin
            a = sel + 23'(k % 4);
            exp_addr.push_back(a);
            if (k < n_samp) exp_samp.push_back(a[15:0]);
        end
        applyStimulus(1'b1, sel, 1'b0, 1'b0, period);
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(tag, done_count != d0, 1);
    endtask

    initial begin
        int          n;
        int          r0;
        int          d0;
        int          s0;
        int          u0;
        logic        req_held;

        i_rst = 1'b0;
        i_mem_ack = 1'b0;
        i_mem_rdata = '0;
        i_dac_req = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        #1 i_rst = 1'b1;
        repeat (3) tick();
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_mem_req", o_mem_req, 0);
        checkOutput("rst_mem_addr", o_mem_addr, 0);
        checkOutput("rst_dac_data", o_dac_data, 0);
        checkOutput("rst_underrun", o_underrun, 0);
        i_rst = 1'b0;
        tick();

        $display("[TB] single pass from 0x100");
        r0 = req_count; s0 = sample_count; u0 = underrun_count;
        startPlay(23'h100, 4, 4, 20);
        waitDone("t1_done", 400);
        checkOutput("t1_req_count", req_count - r0, 4);
        checkOutput("t1_samples", sample_count - s0, 4);
        checkOutput("t1_no_underrun", underrun_count - u0, 0);
        checkOutput("t1_last_sample", o_dac_data, 16'h0103);

        $display("[TB] i_start held after done");
        d0 = done_count;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("t2_no_retrigger", o_mem_req, 0);
        end
        checkOutput("t2_single_done", done_count - d0, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        r0 = req_count; s0 = sample_count;
        startPlay(23'h200, 4, 4, 20);
        waitDone("t2_restart_done", 400);
        checkOutput("t2_req_count", req_count - r0, 4);
        checkOutput("t2_samples", sample_count - s0, 4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();

        $display("[TB] stop during memory handshake");
        startPlay(23'h300, 1, 0, 20);
        n = 0;
        while (o_mem_req !== 1'b1 && n < 20) begin tick(); n++; end
        checkOutput("t3_req_seen", o_mem_req, 1);
        applyStimulus(1'b1, 23'h300, 1'b0, 1'b1, 20);
        n = 0; req_held = 1'b1;
        while (!i_mem_ack && n < 20) begin
            tick();
            n++;
            if (o_mem_req !== 1'b1) req_held = 1'b0;
        end
        checkOutput("t3_ack_seen", i_mem_ack, 1);
        checkOutput("t3_req_held", req_held, 1);
        tick();
        checkOutput("t3_done_after_ack", o_done, 1);
        checkOutput("t3_dac_zero", o_dac_data, 0);
        checkOutput("t3_req_dropped", o_mem_req, 0);
        checkOutput("t3_data_discarded", model_full, 0);
        tick();
        checkOutput("t3_done_one_cycle", o_done, 0);
        checkOutput("t3_dac_still_zero", o_dac_data, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();

        $display("[TB] pause after second sample");
        r0 = req_count; s0 = sample_count; u0 = underrun_count;
        startPlay(23'h100, 4, 4, 20);
        n = 0;
        while (sample_count < s0 + 2 && n < 300) begin tick(); n++; end
        checkOutput("t4_two_samples", sample_count - s0, 2);
        applyStimulus(1'b1, 23'h100, 1'b1, 1'b0, 7);
        for (int k = 0; k < 100; k++) begin
            tick();
            checkOutput("t4_pause_hold", o_dac_data, 16'h0101);
            checkOutput("t4_pause_no_req", o_mem_req, 0);
        end
        checkOutput("t4_pause_req_count", req_count - r0, 2);
        checkOutput("t4_pause_no_underrun", underrun_count - u0, 0);
        applyStimulus(1'b1, 23'h100, 1'b0, 1'b0, 20);
        waitDone("t4_done", 400);
        checkOutput("t4_samples", sample_count - s0, 4);
        checkOutput("t4_req_count", req_count - r0, 4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();

        $display("[TB] fast codec requests");
        s0 = sample_count; u0 = underrun_count;
        startPlay(23'h500, 4, 4, 2);
        waitDone("t5_done", 400);
        checkOutput("t5_underrun_seen", underrun_count > u0, 1);
        checkOutput("t5_samples", sample_count - s0, 4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();

        $display("[TB] address wrap at top of memory");
        r0 = req_count; s0 = sample_count; d0 = done_count;
`ifdef PLAY_LOOP_EN
        startPlay(23'h7FFFFE, 5, 4, 20);
        n = 0;
        while (req_count < r0 + 5 && n < 500) begin tick(); n++; end
        checkOutput("t6_loop_reqs", req_count - r0, 5);
        checkOutput("t6_loop_no_done", done_count - d0, 0);
        applyStimulus(1'b1, 23'h7FFFFE, 1'b0, 1'b1, 20);
        waitDone("t6_stop_done", 50);
`else
        startPlay(23'h7FFFFE, 4, 4, 20);
        waitDone("t6_done", 400);
        checkOutput("t6_req_count", req_count - r0, 4);
`endif
        checkOutput("t6_samples", sample_count - s0, 4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();

        $display("[TB] asynchronous reset mid-playback");
        d0 = done_count;
        startPlay(23'h600, 1, 0, 0);
        n = 0;
        while (o_mem_req !== 1'b1 && n < 20) begin tick(); n++; end
        checkOutput("t7_req_seen", o_mem_req, 1);
        #3 i_rst = 1'b1;
        #1;
        checkOutput("t7_rst_req", o_mem_req, 0);
        checkOutput("t7_rst_addr", o_mem_addr, 0);
        checkOutput("t7_rst_done", o_done, 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        i_rst = 1'b0;
        repeat (5) tick();
        checkOutput("t7_no_done", done_count - d0, 0);
        checkOutput("addr_queue_empty", exp_addr.size(), 0);
        checkOutput("samp_queue_empty", exp_samp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
